// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for a single register-file write port.
// Each port feeds a one-entry buffer; buffers drain oldest-first, ties round-robin.
module regfile_wb_arbiter #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [REG_AW-1:0]      a_wsel,
    input  logic [WORD_W-1:0]      a_wdat,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [REG_AW-1:0]      b_wsel,
    input  logic [WORD_W-1:0]      b_wdat,
    output logic                   WEN,
    output logic [REG_AW-1:0]      wsel,
    output logic [WORD_W-1:0]      wdat,
    output logic [2**REG_AW-1:0]   pend_mask,
    output logic                   busy
);

    typedef enum logic [1:0] {AGE_EQ, AGE_A_OLD, AGE_B_OLD} age_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    logic              bufa_valid, bufb_valid;
    logic [REG_AW-1:0] bufa_wsel, bufb_wsel;
    logic [WORD_W-1:0] bufa_wdat, bufb_wdat;
    age_t              age_q, age_d;
    port_t             last_grant_q, last_grant_d;
    logic              acc_a, acc_b, tie, grant_a, grant_b;

    // Handshake: x_ready depends only on buffer state; a transfer happens on a
    // rising edge with x_valid && x_ready, and a stalled requester holds its
    // valid/wsel/wdat until that edge. Writes to register 0 are accepted and dropped.
    assign a_ready = !bufa_valid;
    assign b_ready = !bufb_valid;

    always_comb begin
        acc_a        = a_valid && a_ready && (a_wsel != '0);
        acc_b        = b_valid && b_ready && (b_wsel != '0);
        tie          = bufa_valid && bufb_valid && (age_q == AGE_EQ);
        grant_a      = bufa_valid && (!bufb_valid || (age_q == AGE_A_OLD) ||
                                      (tie && (last_grant_q == PORT_B)));
        grant_b      = bufb_valid && !grant_a;
        last_grant_d = last_grant_q;
        if (tie)
            last_grant_d = grant_a ? PORT_A : PORT_B;
        // A buffer that survives the edge is older than one filled at that edge.
        age_d = AGE_EQ;
        if (bufa_valid && !grant_a && acc_b)
            age_d = AGE_A_OLD;
        else if (bufb_valid && !grant_b && acc_a)
            age_d = AGE_B_OLD;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bufa_valid   <= 1'b0;
            bufa_wsel    <= '0;
            bufa_wdat    <= '0;
            bufb_valid   <= 1'b0;
            bufb_wsel    <= '0;
            bufb_wdat    <= '0;
            age_q        <= AGE_EQ;
            last_grant_q <= PORT_B;
        end else begin
            age_q        <= age_d;
            last_grant_q <= last_grant_d;
            if (acc_a) begin
                bufa_valid <= 1'b1;
                bufa_wsel  <= a_wsel;
                bufa_wdat  <= a_wdat;
            end else if (grant_a) begin
                bufa_valid <= 1'b0;
            end
            if (acc_b) begin
                bufb_valid <= 1'b1;
                bufb_wsel  <= b_wsel;
                bufb_wdat  <= b_wdat;
            end else if (grant_b) begin
                bufb_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            WEN  <= 1'b0;
            wsel <= '0;
            wdat <= '0;
        end else begin
            WEN <= grant_a || grant_b;
            if (grant_a) begin
                wsel <= bufa_wsel;
                wdat <= bufa_wdat;
            end else if (grant_b) begin
                wsel <= bufb_wsel;
                wdat <= bufb_wdat;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        if (bufa_valid)
            pend_mask[bufa_wsel] = 1'b1;
        if (bufb_valid)
            pend_mask[bufb_wsel] = 1'b1;
        if (WEN)
            pend_mask[wsel] = 1'b1;
    end

    assign busy = bufa_valid || bufb_valid || WEN;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a timestamp-based reference model and an expected-write queue.
module tb_regfile_wb_arbiter;
    localparam int WORD_W = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    logic              CLK;
    logic              nRST;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [REG_AW-1:0] a_wsel, b_wsel, wsel;
    logic [WORD_W-1:0] a_wdat, b_wdat, wdat;
    logic              WEN;
    logic [NREG-1:0]   pend_mask;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [REG_AW+WORD_W-1:0] exp_q[$];

    // Reference model: buffered entries carry their arrival cycle.
    bit                m_v[2];
    logic [REG_AW-1:0] m_sel[2];
    logic [WORD_W-1:0] m_dat[2];
    int                m_t[2];
    int                m_last;
    bit                m_wen;
    logic [REG_AW-1:0] m_wsel;
    logic [WORD_W-1:0] m_wdat;
    int                m_cyc;
    logic [WORD_W-1:0] m_rf[NREG];
    bit                m_written[NREG];

    logic [WORD_W-1:0] rf[NREG];

    regfile_wb_arbiter #(.WORD_W(WORD_W), .REG_AW(REG_AW)) dut (
        .CLK(CLK), .nRST(nRST),
        .a_valid(a_valid), .a_ready(a_ready), .a_wsel(a_wsel), .a_wdat(a_wdat),
        .b_valid(b_valid), .b_ready(b_ready), .b_wsel(b_wsel), .b_wdat(b_wdat),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .pend_mask(pend_mask), .busy(busy)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file captures on the falling edge
    always @(negedge CLK)
        if (nRST && WEN) rf[wsel] <= wdat;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) m_v[i] = 0;
        m_last = 1;
        m_wen  = 0;
        m_wsel = '0;
        m_wdat = '0;
        m_cyc  = 0;
        for (int i = 0; i < NREG; i++) m_written[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int g;
        bit acc0, acc1;
        g = -1;
        if (m_v[0] && m_v[1]) begin
            if (m_t[0] < m_t[1]) g = 0;
            else if (m_t[1] < m_t[0]) g = 1;
            else begin
                g = (m_last == 1) ? 0 : 1;
                m_last = g;
            end
        end else if (m_v[0]) g = 0;
        else if (m_v[1]) g = 1;
        acc0 = (a_valid === 1'b1) && !m_v[0] && (a_wsel != '0);
        acc1 = (b_valid === 1'b1) && !m_v[1] && (b_wsel != '0);
        if (g >= 0) begin
            m_wen  = 1;
            m_wsel = m_sel[g];
            m_wdat = m_dat[g];
            m_v[g] = 0;
            exp_q.push_back({m_wsel, m_wdat});
            m_rf[m_wsel] = m_wdat;
            m_written[m_wsel] = 1;
        end else begin
            m_wen = 0;
        end
        if (acc0) begin
            m_v[0] = 1; m_sel[0] = a_wsel; m_dat[0] = a_wdat; m_t[0] = m_cyc;
        end
        if (acc1) begin
            m_v[1] = 1; m_sel[1] = b_wsel; m_dat[1] = b_wdat; m_t[1] = m_cyc;
        end
        m_cyc++;
    endtask

    function automatic logic [NREG-1:0] model_pend();
        logic [NREG-1:0] p;
        p = '0;
        for (int i = 0; i < 2; i++)
            if (m_v[i]) p[m_sel[i]] = 1'b1;
        if (m_wen) p[m_wsel] = 1'b1;
        return p;
    endfunction

    // Driver tasks
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({a_ready, b_ready, WEN, busy} !== 4'b1100 || wsel !== '0 || wdat !== '0 || pend_mask !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b%b WEN=%b busy=%b wsel=%0d wdat=%h pend=%h, want 11 0 0 0 0 0",
                     a_ready, b_ready, WEN, busy, wsel, wdat, pend_mask);
        end
        a_valid = 1'b1; a_wsel = 5'd4; a_wdat = $urandom;
        b_valid = 1'b1; b_wsel = 5'd9; b_wdat = $urandom;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tests_run++;
        if (pend_mask !== 32'h0000_0210) begin
            tests_failed++;
            $display("FAIL reset_fill_pend: got %h want 00000210", pend_mask);
        end
        tick();
        tests_run++;
        if (WEN !== 1'b1 || b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pre_state: WEN=%b b_ready=%b want 1 0", WEN, b_ready);
        end
        #2 nRST = 1'b0;
        #1;
        tests_run++;
        if ({WEN, a_ready, b_ready, busy} !== 4'b0110 || pend_mask !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: WEN=%b rdy=%b%b busy=%b pend=%h want 0 11 0 0",
                     WEN, a_ready, b_ready, busy, pend_mask);
        end
        @(posedge CLK);
        #1 nRST = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (WEN !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_write c%0d: WEN=%b busy=%b want 0 0", i, WEN, busy);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        a_valid = 1'b1; a_wsel = 5'd5; a_wdat = 32'hDEADBEEF;
        tick();
        a_valid = 1'b0;
        tests_run++;
        if (a_ready !== 1'b0 || pend_mask[5] !== 1'b1 || WEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_k: a_ready=%b pend5=%b WEN=%b want 0 1 0", a_ready, pend_mask[5], WEN);
        end
        tick();
        tests_run++;
        if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF || a_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_k1: WEN=%b wsel=%0d wdat=%h a_ready=%b want 1 5 deadbeef 1",
                     WEN, wsel, wdat, a_ready);
        end
        tick();
        tests_run++;
        if (WEN !== 1'b0 || busy !== 1'b0 || rf[5] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_k2: WEN=%b busy=%b rf5=%h want 0 0 deadbeef", WEN, busy, rf[5]);
        end
    endtask

    task automatic test_tie_fairness();
        logic [REG_AW-1:0] want[4];
        want[0] = 5'd1; want[1] = 5'd2; want[2] = 5'd2; want[3] = 5'd1;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            a_valid = 1'b1; a_wsel = 5'd1; a_wdat = 32'd1;
            b_valid = 1'b1; b_wsel = 5'd2; b_wdat = 32'd2;
            tick();
            a_valid = 1'b0; b_valid = 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick();
                tests_run++;
                if (WEN !== 1'b1 || wsel !== want[2*p+j] || wdat !== 32'(want[2*p+j])) begin
                    tests_failed++;
                    $display("FAIL tie_pair%0d_w%0d: WEN=%b wsel=%0d wdat=%0d want 1 %0d %0d",
                             p, j, WEN, wsel, wdat, want[2*p+j], want[2*p+j]);
                end
            end
        end
    endtask

    task automatic test_age_order();
        do_reset();
        b_valid = 1'b1; b_wsel = 5'd7; b_wdat = 32'h11;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_wsel = 5'd7; a_wdat = 32'h22;
        tick();
        a_valid = 1'b0;
        tests_run++;
        if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h11) begin
            tests_failed++;
            $display("FAIL age_first: WEN=%b wsel=%0d wdat=%h want 1 7 11", WEN, wsel, wdat);
        end
        tick();
        tests_run++;
        if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h22) begin
            tests_failed++;
            $display("FAIL age_second: WEN=%b wsel=%0d wdat=%h want 1 7 22", WEN, wsel, wdat);
        end
        tick();
        tests_run++;
        if (rf[7] !== 32'h22 || WEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL age_final: rf7=%h WEN=%b want 22 0", rf[7], WEN);
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        a_valid = 1'b1; a_wsel = 5'd0; a_wdat = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (a_ready !== 1'b1 || WEN !== 1'b0 || pend_mask[0] !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reg_zero c%0d: a_ready=%b WEN=%b pend0=%b busy=%b want 1 0 0 0",
                         i, a_ready, WEN, pend_mask[0], busy);
            end
        end
        a_valid = 1'b0;
        tick();
        tests_run++;
        if (WEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL reg_zero_tail: WEN=%b want 0", WEN);
        end
    endtask

    task automatic test_backpressure();
        logic exp_wen;
        do_reset();
        for (int e = 0; e < 10; e++) begin
            a_valid = 1'b1; a_wsel = 5'd3; a_wdat = 32'h100 + 32'(e);
            tick();
            exp_wen = (e % 2) == 1;
            tests_run++;
            if (WEN !== exp_wen || a_ready !== exp_wen ||
                (exp_wen && wdat !== 32'h100 + 32'(e - 1))) begin
                tests_failed++;
                $display("FAIL backpressure e%0d: WEN=%b a_ready=%b wdat=%h want %b %b %h",
                         e, WEN, a_ready, wdat, exp_wen, exp_wen, 32'h100 + 32'(e - 1));
            end
        end
        a_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [REG_AW+WORD_W-1:0] got, want;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(a_valid && m_v[0])) begin
                a_valid = $urandom_range(0, 9) < 6;
                a_wsel  = 5'($urandom_range(0, 7));
                a_wdat  = $urandom;
            end
            if (!(b_valid && m_v[1])) begin
                b_valid = $urandom_range(0, 9) < 6;
                b_wsel  = 5'($urandom_range(0, 7));
                b_wdat  = $urandom;
            end
            tick();
            tests_run++;
            if (a_ready !== !m_v[0] || b_ready !== !m_v[1] || WEN !== m_wen ||
                (m_wen && (wsel !== m_wsel || wdat !== m_wdat))) begin
                tests_failed++;
                $display("FAIL rand_out c%0d: rdy=%b%b WEN=%b wsel=%0d wdat=%h want %b%b %b %0d %h",
                         c, a_ready, b_ready, WEN, wsel, wdat, !m_v[0], !m_v[1], m_wen, m_wsel, m_wdat);
            end
            tests_run++;
            if (pend_mask !== model_pend() || busy !== (m_v[0] || m_v[1] || m_wen)) begin
                tests_failed++;
                $display("FAIL rand_pend c%0d: pend=%h busy=%b want %h %b",
                         c, pend_mask, busy, model_pend(), m_v[0] || m_v[1] || m_wen);
            end
            if (WEN === 1'b1) begin
                tests_run++;
                got = {wsel, wdat};
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_sb c%0d: got write %h want none", c, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        tests_failed++;
                        $display("FAIL rand_sb c%0d: got %h want %h", c, got, want);
                    end
                end
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < NREG; i++) begin
            if (m_written[i]) begin
                tests_run++;
                if (rf[i] !== m_rf[i]) begin
                    tests_failed++;
                    $display("FAIL rand_rf r%0d: got %h want %h", i, rf[i], m_rf[i]);
                end
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_drain: busy=%b want 0", busy);
        end
    endtask

    initial begin
        nRST = 1'b0;
        a_valid = 1'b0; a_wsel = '0; a_wdat = '0;
        b_valid = 1'b0; b_wsel = '0; b_wdat = '0;
        test_reset();
        test_single_write();
        test_tie_fairness();
        test_age_order();
        test_reg_zero();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WEN/wsel/wdat) between two writeback requesters.
  - Port A: ALU/execute writeback.
  - Port B: load/memory writeback.
- Each requester has a valid/ready handshake into a one-entry holding buffer.
- The arbiter drains the buffers oldest-first, with ties broken round-robin.
- Registered outputs drive the register file's write port. Exports a pending-write mask for hazard/stall logic.

Parameters:
WORD_W, 32, data width of a register write
REG_AW, 5, register select width (2**REG_AW registers)

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  asynchronous active-low reset
a_valid  in  1  port A write request
a_ready  out  1  port A buffer can accept
a_wsel  in  REG_AW  port A destination register
a_wdat  in  WORD_W  port A write data
b_valid  in  1  port B write request
b_ready  out  1  port B buffer can accept
b_wsel  in  REG_AW  port B destination register
b_wdat  in  WORD_W  port B write data
WEN  out  1  register-file write enable (registered)
wsel  out  REG_AW  register-file write select (registered)
wdat  out  WORD_W  register-file write data (registered)
pend_mask  out  2**REG_AW  bit i set if a write to register i is buffered or on the output
busy  out  1  any buffer or output register valid

Behaviour:
- Reset (nRST low, asynchronous):
  - Buffers empty; WEN=0, wsel=0, wdat=0.
  - last_grant=B, so the first tie goes to A.
  - age flag cleared.
  - Resulting outputs: a_ready=b_ready=1, pend_mask=0, busy=0.
- Reset mid-operation discards all buffered writes; none reach the register file.
- Handshake:
  - x_ready = !bufx_valid, combinational from state only, never from x_valid.
  - Transfer when x_valid && x_ready at a rising edge.
  - A stalled requester (ready=0) must hold valid/wsel/wdat stable. The block samples them only on transfer.
- Register 0:
  - A transfer with wsel==0 is accepted (ready honoured) but discarded.
  - It is not buffered, never asserts WEN, and never sets pend_mask[0].
- Age tracking:
  - One flag records which buffer was filled first.
  - If both are accepted in the same edge, they are of equal age.
- Grant, evaluated each edge from buffer state before that edge's accepts:
  - If only one buffer is valid, grant it.
  - If both are valid, grant the older one.
  - If equal age, grant the port opposite last_grant, then update last_grant.
- A granted entry moves into the output register: WEN<=1, wsel/wdat<=entry. Its buffer clears at the same edge.
  - A new transfer into a buffer is not possible at its draining edge, because ready was 0 entering that edge.
- No grant in a cycle → WEN<=0. wsel/wdat hold their last value.
- Latency:
  - Transfer at edge k → WEN high for the cycle after edge k+1, when uncontended.
  - The register file captures on the falling edge inside that cycle, so WEN/wsel/wdat are stable across it.
- Throughput: one write per cycle aggregate. A single port sustains one write every 2 cycles (buffer re-accepts the edge after draining).
- Same destination in both buffers: the older write is granted first. The younger value is the final register content.
- pend_mask: OR of decoded bufa.wsel (if valid), bufb.wsel (if valid), and wsel (if WEN). Combinational from registers only.
- busy = bufa_valid | bufb_valid | WEN.

Test Plan:
- Reset: assert nRST low mid-stream with both buffers full and WEN=1 → same cycle WEN=0, a_ready=b_ready=1, pend_mask=0. No further writes after release.
- Single write: A writes r5=0xDEADBEEF at edge k → a_ready=0 and pend_mask[5]=1 after k. WEN=1, wsel=5, wdat=0xDEADBEEF after k+1. WEN=0 after k+2.
- Tie fairness: A(r1=1) and B(r2=2) accepted same edge, twice in succession.
  - First pair: r1 then r2.
  - Second pair: r2 then r1 (round-robin).
  - Also covers two consecutive WEN=1 cycles.
- Age ordering:
  - B(r7=0x11) accepted at k, A(r7=0x22) at k+1.
  - Required: B is granted first (0x11, then 0x22), and r7 ends at 0x22.
- Register zero: A wsel=0, wdat=0xFFFFFFFF → accepted, a_ready stays 1. WEN never asserts; pend_mask[0]=0 throughout.
- Backpressure: hold a_valid=1 with changing data while a_ready=0. Only values present at ready edges are written, in order, one per 2 cycles.
